// File: rtl/traffic_light_controller_if.sv
// Lamp bundle for the four approaches of the T-junction controller.
// Each lamp is one-hot {red, yellow, green}.
interface traffic_light_controller_if;
    logic [2:0] light_M1;
    logic [2:0] light_S;
    logic [2:0] light_MT;
    logic [2:0] light_M2;

    modport master (
        output light_M1,
        output light_S,
        output light_MT,
        output light_M2
    );

    modport slave (
        input light_M1,
        input light_S,
        input light_MT,
        input light_M2
    );
endinterface

// File: rtl/traffic_light_controller.sv
// Six-phase timed Moore sequencer for a T-junction (main, turn lane, side road).
// A per-phase counter sets each phase length; lamps decode from the state only.
module traffic_light_controller #(
    parameter int unsigned T_MG  = 7,
    parameter int unsigned T_Y   = 2,
    parameter int unsigned T_TG  = 5,
    parameter int unsigned T_SG  = 3,
    parameter int unsigned CNT_W = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    traffic_light_controller_if.master    lights
);

    typedef enum logic [2:0] {
        S1 = 3'd0,
        S2 = 3'd1,
        S3 = 3'd2,
        S4 = 3'd3,
        S5 = 3'd4,
        S6 = 3'd5
    } state_t;

    localparam logic [2:0] RED    = 3'b100;
    localparam logic [2:0] YELLOW = 3'b010;
    localparam logic [2:0] GREEN  = 3'b001;

    state_t           state_r;
    state_t           state_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_s;
    logic [CNT_W-1:0] dur_s;
    logic [2:0]       m1_s;
    logic [2:0]       m2_s;
    logic [2:0]       mt_s;
    logic [2:0]       s_s;

    function automatic logic [CNT_W-1:0] phase_len(input state_t st);
        case (st)
            S1:      phase_len = CNT_W'(T_MG);
            S3:      phase_len = CNT_W'(T_TG);
            S5:      phase_len = CNT_W'(T_SG);
            default: phase_len = CNT_W'(T_Y);
        endcase
    endfunction

    function automatic state_t phase_next(input state_t st);
        case (st)
            S1:      phase_next = S2;
            S2:      phase_next = S3;
            S3:      phase_next = S4;
            S4:      phase_next = S5;
            S5:      phase_next = S6;
            default: phase_next = S1;
        endcase
    endfunction

    // State and phase-counter registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= S1;
            cnt_r   <= '0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
        end
    end

    // Next-state and counter logic; counter only ever compared against D-1
    always_comb begin
        state_s = S1;
        cnt_s   = '0;
        dur_s   = phase_len(state_r);
        case (state_r)
            S1, S2, S3, S4, S5, S6: begin
                if (cnt_r == dur_s - CNT_W'(1)) begin
                    state_s = phase_next(state_r);
                    cnt_s   = '0;
                end else begin
                    state_s = state_r;
                    cnt_s   = cnt_r + CNT_W'(1);
                end
            end
            default: begin
                state_s = S1;
                cnt_s   = '0;
            end
        endcase
    end

    // Moore lamp decode; an unreachable encoding shows all-red
    always_comb begin
        m1_s = RED;
        m2_s = RED;
        mt_s = RED;
        s_s  = RED;
        case (state_r)
            S1: begin m1_s = GREEN;  m2_s = GREEN;  end
            S2: begin m1_s = GREEN;  m2_s = YELLOW; end
            S3: begin m1_s = GREEN;  mt_s = GREEN;  end
            S4: begin m1_s = YELLOW; mt_s = YELLOW; end
            S5: begin s_s  = GREEN;  end
            S6: begin s_s  = YELLOW; end
            default: begin
                m1_s = RED;
                m2_s = RED;
                mt_s = RED;
                s_s  = RED;
            end
        endcase
    end

    assign lights.light_M1 = m1_s;
    assign lights.light_M2 = m2_s;
    assign lights.light_MT = mt_s;
    assign lights.light_S  = s_s;

endmodule

// File: tb/tb_traffic_light_controller.sv
// Self-checking bench for traffic_light_controller: phase-window vectors,
// reset corner cases and random reset pulses against a cycle-index model.
module tb_traffic_light_controller;

    localparam int T_MG = 7;
    localparam int T_Y  = 2;
    localparam int T_TG = 5;
    localparam int T_SG = 3;
    localparam int PERIOD = T_MG + T_Y + T_TG + T_Y + T_SG + T_Y;

    localparam logic [2:0] R = 3'b100;
    localparam logic [2:0] Y = 3'b010;
    localparam logic [2:0] G = 3'b001;

    typedef struct {
        int         cyc;
        logic [2:0] m1;
        logic [2:0] m2;
        logic [2:0] mt;
        logic [2:0] s;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   k = 0;
    vec_t vecs[13];

    traffic_light_controller_if lights();

    traffic_light_controller #(
        .T_MG(T_MG), .T_Y(T_Y), .T_TG(T_TG), .T_SG(T_SG), .CNT_W(8)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .lights (lights)
    );

    always #5 clk = ~clk;

    // Reference: phase from cycle index within the repeating sequence
    task automatic model(input int cyc, output logic [2:0] m1, output logic [2:0] m2,
                         output logic [2:0] mt, output logic [2:0] s);
        int dur[6];
        logic [2:0] m1_t[6];
        logic [2:0] m2_t[6];
        logic [2:0] mt_t[6];
        logic [2:0] s_t[6];
        int t;
        int p;
        dur  = '{T_MG, T_Y, T_TG, T_Y, T_SG, T_Y};
        m1_t = '{G, G, G, Y, R, R};
        m2_t = '{G, Y, R, R, R, R};
        mt_t = '{R, R, G, Y, R, R};
        s_t  = '{R, R, R, R, G, Y};
        t = cyc % PERIOD;
        p = 0;
        while (t >= dur[p]) begin
            t = t - dur[p];
            p = p + 1;
        end
        m1 = m1_t[p];
        m2 = m2_t[p];
        mt = mt_t[p];
        s  = s_t[p];
    endtask

    task automatic check(input string name, input logic [2:0] act, input logic [2:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d got=%b want=%b t=%0t", name, k, act, exp, $time);
        end
    endtask

    task automatic check_lamps(input string tag, input logic [2:0] m1, input logic [2:0] m2,
                               input logic [2:0] mt, input logic [2:0] s);
        check({tag, ".M1"}, lights.light_M1, m1);
        check({tag, ".M2"}, lights.light_M2, m2);
        check({tag, ".MT"}, lights.light_MT, mt);
        check({tag, ".S"},  lights.light_S,  s);
    endtask

    task automatic check_safety();
        logic ok;
        ok = $onehot(lights.light_M1) && $onehot(lights.light_M2) &&
             $onehot(lights.light_MT) && $onehot(lights.light_S);
        if ((lights.light_S == G || lights.light_S == Y) &&
            (lights.light_M1 != R || lights.light_M2 != R || lights.light_MT != R))
            ok = 1'b0;
        if (lights.light_MT == G && lights.light_M2 != R)
            ok = 1'b0;
        check("safety", {2'b00, ok}, 3'b001);
    endtask

    task automatic check_model(input string tag);
        logic [2:0] m1, m2, mt, s;
        model(k, m1, m2, mt, s);
        check_lamps(tag, m1, m2, mt, s);
        check_safety();
    endtask

    task automatic step();
        @(negedge clk);
        #1;
        k++;
    endtask

    // Release reset away from the rising edge; next rising edge is cycle 0
    task automatic restart();
        @(negedge clk);
        rst = 1'b1;
        #1;
        k = 0;
    endtask

    initial begin
        int seq_count;
        logic prev_s6;
        vecs[0]  = '{0,  G, G, R, R};
        vecs[1]  = '{6,  G, G, R, R};
        vecs[2]  = '{7,  G, Y, R, R};
        vecs[3]  = '{8,  G, Y, R, R};
        vecs[4]  = '{9,  G, R, G, R};
        vecs[5]  = '{13, G, R, G, R};
        vecs[6]  = '{14, Y, R, Y, R};
        vecs[7]  = '{15, Y, R, Y, R};
        vecs[8]  = '{16, R, R, R, G};
        vecs[9]  = '{18, R, R, R, G};
        vecs[10] = '{19, R, R, R, Y};
        vecs[11] = '{20, R, R, R, Y};
        vecs[12] = '{21, G, G, R, R};

        // Reset hold: S1 pattern on both clock phases while rst is low
        rst = 1'b0;
        #2;
        check_lamps("rst_hold0", G, G, R, R);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check_lamps("rst_hold_pe", G, G, R, R);
            @(negedge clk);
            #1;
            check_lamps("rst_hold_ne", G, G, R, R);
        end

        // Phase-window vectors from the first edge after release
        restart();
        foreach (vecs[i]) begin
            while (k < vecs[i].cyc) step();
            check_lamps("vec", vecs[i].m1, vecs[i].m2, vecs[i].mt, vecs[i].s);
        end

        // 200-cycle run from a fresh release: model, safety and sequence count
        @(negedge clk);
        rst = 1'b0;
        restart();
        seq_count = 0;
        prev_s6 = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (i != 0) step();
            check_model("run");
            if (prev_s6 && lights.light_M1 == G && lights.light_M2 == G)
                seq_count++;
            prev_s6 = (lights.light_S == Y);
        end
        checks++;
        if (seq_count != 9) begin
            errors++;
            $display("FAIL seq_count got=%0d want=9", seq_count);
        end
        check_lamps("run_tail", G, R, G, R);

        // Async reset pulled mid-cycle while in S5
        while ((k % PERIOD) != 17) step();
        check_lamps("pre_async_s5", R, R, R, G);
        #2;
        rst = 1'b0;
        #1;
        check_lamps("async_s5", G, G, R, R);
        @(posedge clk);
        #1;
        check_lamps("async_s5_hold", G, G, R, R);

        // Mid-operation reset during S3 restarts with a full-length S1
        restart();
        while (k < 10) step();
        check_lamps("pre_mid_s3", G, R, G, R);
        #2;
        rst = 1'b0;
        #1;
        check_lamps("mid_s3_rst", G, G, R, R);
        restart();
        for (int i = 0; i < 9; i++) begin
            if (i != 0) step();
            check_model("mid_restart");
        end
        check_lamps("mid_restart_s2", G, Y, R, R);

        // Random run lengths with random mid-cycle reset pulses
        for (int r = 0; r < 20; r++) begin
            int len;
            len = int'($urandom_range(1, 45));
            for (int i = 0; i < len; i++) begin
                step();
                check_model("rand");
            end
            #($urandom_range(1, 3));
            rst = 1'b0;
            #1;
            check_lamps("rand_rst", G, G, R, R);
            if ($urandom_range(0, 1) == 1) begin
                @(posedge clk);
                #1;
                check_lamps("rand_rst_hold", G, G, R, R);
            end
            restart();
            check_model("rand_c0");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
